// File: rtl/timer_pkg.sv
// Shared register indices, compare-output modes and CTRL layout for the
// compare timer peripheral.
package timer_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PRESCALE = 3'd1;
    localparam logic [2:0] REG_COMPARE  = 3'd2;
    localparam logic [2:0] REG_COUNTER  = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_PULSE  = 2'b10,
        MODE_PWM    = 2'b11
    } mode_e;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_MODE_LO    = 1;
    localparam int CTRL_MODE_HI    = 2;
    localparam int CTRL_AUTORELOAD = 3;
    localparam int CTRL_IRQEN      = 4;

    // Field order mirrors the CTRL bit positions (en is bit 0).
    typedef struct packed {
        logic  irqen;
        logic  autoreload;
        mode_e mode;
        logic  en;
    } ctrl_t;

endpackage

// File: rtl/compare_timer_if.sv
// Peripheral data bus slice seen by one compare timer instance.
interface compare_timer_if;
    logic        sel;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, we, addr, wdata, input  rdata);
    modport slave  (input  sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/timer_prescaler.sv
// Clock divider: one-cycle tick every (divisor+1) enabled clocks.
module timer_prescaler #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_en,
    input  logic                      i_clear,
    input  logic [PRESCALE_WIDTH-1:0] i_divisor,
    output logic                      o_tick
);
    logic [PRESCALE_WIDTH-1:0] r_pcnt;

    assign o_tick = i_en && (r_pcnt == i_divisor);

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_pcnt <= '0;
        else if (i_clear || o_tick)
            r_pcnt <= '0;
        else if (i_en)
            r_pcnt <= r_pcnt + 1'b1;
    end
endmodule

// File: rtl/compare_timer.sv
// Memory-mapped up-counter with compare register, compare output pin
// (off/toggle/pulse/PWM) and a level interrupt on the sticky MATCH flag.
module compare_timer
    import timer_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    compare_timer_if.slave  bus,
    output logic            o_cmp_out,
    output logic            o_irq
);
    ctrl_t                     r_ctrl;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [WIDTH-1:0]          r_compare;
    logic [WIDTH-1:0]          r_counter;
    logic                      r_match;
    logic                      r_cmp;
    logic                      r_irq;
    logic [31:0]               r_rdata;

    logic             w_wr, w_rd, w_cnt_wr, w_pre_wr, w_status_clr;
    logic             w_tick, w_match_evt;
    logic [WIDTH-1:0] w_counter_next;
    logic [31:0]      w_rd_val;
    ctrl_t            w_ctrl_wdata;

    assign w_wr         = bus.sel && bus.we;
    assign w_rd         = bus.sel && !bus.we;
    assign w_cnt_wr     = w_wr && (bus.addr == REG_COUNTER);
    assign w_pre_wr     = w_wr && (bus.addr == REG_PRESCALE);
    assign w_status_clr = w_wr && (bus.addr == REG_STATUS) && bus.wdata[0];

    assign w_ctrl_wdata = '{irqen:      bus.wdata[CTRL_IRQEN],
                            autoreload: bus.wdata[CTRL_AUTORELOAD],
                            mode:       mode_e'(bus.wdata[CTRL_MODE_HI:CTRL_MODE_LO]),
                            en:         bus.wdata[CTRL_EN]};

    timer_prescaler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_prescaler (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_en      (r_ctrl.en),
        .i_clear   (w_cnt_wr || w_pre_wr),
        .i_divisor (r_prescale),
        .o_tick    (w_tick)
    );

    // A bus load of COUNTER swallows any same-cycle tick, including its match.
    assign w_match_evt = w_tick && !w_cnt_wr && (r_counter == r_compare);

    always_comb begin
        w_counter_next = r_counter;
        if (w_cnt_wr)
            w_counter_next = bus.wdata[WIDTH-1:0];
        else if (w_match_evt && r_ctrl.autoreload)
            w_counter_next = '0;
        else if (w_tick)
            w_counter_next = r_counter + 1'b1;
    end

    always_comb begin
        w_rd_val = '0;
        case (bus.addr)
            REG_CTRL:     w_rd_val = {27'd0, r_ctrl};
            REG_PRESCALE: w_rd_val = 32'(r_prescale);
            REG_COMPARE:  w_rd_val = 32'(r_compare);
            REG_COUNTER:  w_rd_val = 32'(r_counter);
            REG_STATUS:   w_rd_val = {31'd0, r_match};
            default:      w_rd_val = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_compare  <= '0;
            r_counter  <= '0;
            r_match    <= 1'b0;
            r_cmp      <= 1'b0;
            r_irq      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (w_wr) begin
                case (bus.addr)
                    REG_CTRL:     r_ctrl     <= w_ctrl_wdata;
                    REG_PRESCALE: r_prescale <= bus.wdata[PRESCALE_WIDTH-1:0];
                    REG_COMPARE:  r_compare  <= bus.wdata[WIDTH-1:0];
                    default: ;
                endcase
            end
            r_counter <= w_counter_next;

            // Set has priority over a same-cycle software clear.
            if (w_match_evt)
                r_match <= 1'b1;
            else if (w_status_clr)
                r_match <= 1'b0;
            r_irq <= r_match & r_ctrl.irqen;

            case (r_ctrl.mode)
                MODE_OFF:    r_cmp <= 1'b0;
                MODE_TOGGLE: r_cmp <= r_cmp ^ w_match_evt;
                MODE_PULSE:  r_cmp <= w_match_evt;
                MODE_PWM:    if (w_tick) r_cmp <= (w_counter_next < r_compare);
            endcase

            if (w_rd)
                r_rdata <= w_rd_val;
        end
    end

    assign bus.rdata = r_rdata;
    assign o_cmp_out = r_cmp;
    assign o_irq     = r_irq;
endmodule

// File: tb/tb_compare_timer.sv
// Directed stimulus for compare_timer; expectations are queued against a
// cycle number and a negedge monitor checks them when that cycle arrives.
module tb_compare_timer;
    logic clk = 1'b0;
    logic rst;
    logic cmp_out, irq;

    compare_timer_if bus();

    compare_timer #(.WIDTH(16), .PRESCALE_WIDTH(16)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .bus       (bus),
        .o_cmp_out (cmp_out),
        .o_irq     (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int K_RDATA = 0, K_CMP = 1, K_IRQ = 2;

    typedef struct {
        int          at;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic push(input int kind, input int off, input logic [31:0] exp, input string name);
        exp_t e;
        e.at = cyc + off; e.kind = kind; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                case (sb[i].kind)
                    K_RDATA: act = bus.rdata;
                    K_CMP:   act = {31'd0, cmp_out};
                    default: act = {31'd0, irq};
                endcase
                n_chk++;
                if (act === sb[i].exp) n_pass++;
                else $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h",
                              sb[i].name, cyc, act, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        step();
        bus.sel = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
        push(K_RDATA, 1, exp, name);
        step();
        bus.sel = 1'b0;
    endtask

    task automatic clean();
        wr(3'd0, 32'h0);
        wr(3'd4, 32'h1);
        wr(3'd3, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        step(); step();
        n_chk++;
        if (cmp_out === 1'b0) n_pass++;
        else $display("FAIL direct_reset_cmp: got %b", cmp_out);
        n_chk++;
        if (irq === 1'b0) n_pass++;
        else $display("FAIL direct_reset_irq: got %b", irq);
        n_chk++;
        if (bus.rdata === 32'h0) n_pass++;
        else $display("FAIL direct_reset_rdata: got 0x%08h", bus.rdata);
        push(K_RDATA, 0, 32'h0, "reset_rdata");
        push(K_CMP,   0, 32'h0, "reset_cmp");
        push(K_IRQ,   0, 32'h0, "reset_irq");
        rst = 1'b0;
        rd(3'd0, 32'h0, "reset_ctrl");
        rd(3'd3, 32'h0, "reset_counter");

        clean(); wr(3'd1, 32'd3); wr(3'd2, 32'd4); wr(3'd0, 32'h0B);
        push(K_CMP, 19, 32'h0, "t1_cmp_before");
        push(K_CMP, 20, 32'h1, "t1_cmp_toggle1");
        push(K_CMP, 39, 32'h1, "t1_cmp_hold");
        push(K_CMP, 40, 32'h0, "t1_cmp_toggle2");
        push(K_IRQ, 25, 32'h0, "t1_irq_masked");
        idle(4);  rd(3'd3, 32'h1, "t1_counter_first_tick");
        idle(14); rd(3'd4, 32'h0, "t1_match_not_yet");
        rd(3'd4, 32'h1, "t1_match_set");
        idle(20);

        clean(); wr(3'd1, 32'd0); wr(3'd2, 32'd2); wr(3'd0, 32'h1D);
        push(K_CMP, 2, 32'h0, "t2_cmp_low");
        push(K_CMP, 3, 32'h1, "t2_pulse1");
        push(K_CMP, 4, 32'h0, "t2_pulse1_end");
        push(K_CMP, 6, 32'h1, "t2_pulse2");
        push(K_CMP, 7, 32'h0, "t2_pulse2_end");
        push(K_IRQ, 3, 32'h0, "t2_irq_lag");
        push(K_IRQ, 4, 32'h1, "t2_irq_rise");
        push(K_IRQ, 8, 32'h0, "t2_irq_cleared");
        push(K_IRQ, 10, 32'h1, "t2_irq_reraise");
        push(K_IRQ, 13, 32'h1, "t2_irq_set_wins");
        push(K_CMP, 15, 32'h1, "t2_pulse_at_disable");
        push(K_CMP, 16, 32'h0, "t2_pulse_completes");
        push(K_CMP, 18, 32'h0, "t2_cmp_idle");
        idle(6);  wr(3'd4, 32'h1); rd(3'd4, 32'h0, "t2_status_cleared");
        idle(3);  wr(3'd4, 32'h1); rd(3'd4, 32'h1, "t2_status_set_wins");
        idle(1);  wr(3'd0, 32'h1C);
        idle(4);

        clean(); wr(3'd1, 32'd0); wr(3'd2, 32'd3); wr(3'd0, 32'h0F);
        push(K_CMP, 3, 32'h0, "t3_pwm_low");
        push(K_CMP, 4, 32'h1, "t3_pwm_high0");
        push(K_CMP, 5, 32'h1, "t3_pwm_high1");
        push(K_CMP, 6, 32'h1, "t3_pwm_high2");
        push(K_CMP, 7, 32'h0, "t3_pwm_low2");
        push(K_CMP, 8, 32'h1, "t3_pwm_high3");
        push(K_CMP, 12, 32'h1, "t3_pwm_hold");
        idle(8);  wr(3'd0, 32'h0E);
        idle(2);  rd(3'd3, 32'h1, "t3_counter_hold");

        clean(); wr(3'd1, 32'd0); wr(3'd2, 32'd1); wr(3'd3, 32'hFFFE); wr(3'd0, 32'h03);
        push(K_CMP, 3, 32'h0, "t4_no_match_wrap");
        push(K_CMP, 4, 32'h1, "t4_match_toggle");
        idle(1);
        rd(3'd3, 32'hFFFF, "t4_counter_ffff");
        rd(3'd4, 32'h0,    "t4_status_wrap");
        rd(3'd3, 32'h0001, "t4_counter_0001");
        rd(3'd4, 32'h1,    "t4_status_match");

        clean(); wr(3'd1, 32'd1); wr(3'd2, 32'd5); wr(3'd3, 32'd4); wr(3'd0, 32'h0D);
        push(K_CMP, 4, 32'h0, "t5_no_pulse_collide");
        push(K_CMP, 5, 32'h0, "t5_no_pulse_after");
        idle(3);  wr(3'd3, 32'h10);
        rd(3'd4, 32'h0,  "t5_no_match");
        rd(3'd3, 32'h10, "t5_counter_loaded");
        rd(3'd3, 32'h11, "t5_counter_next_tick");
        wr(3'd2, 32'h12);
        idle(1);
        push(K_RDATA, 0, 32'h11, "t5_rdata_holds");
        push(K_RDATA, 1, 32'h0,  "t5_reset_rdata");
        push(K_CMP,   1, 32'h0,  "t5_reset_cmp");
        push(K_IRQ,   1, 32'h0,  "t5_reset_irq");
        rst = 1'b1; step(); rst = 1'b0;
        n_chk++;
        if (cmp_out === 1'b0 && irq === 1'b0) n_pass++;
        else $display("FAIL direct_midcount_reset: cmp=%b irq=%b", cmp_out, irq);
        rd(3'd4, 32'h0, "t5_reset_status");
        rd(3'd0, 32'h0, "t5_reset_ctrl");
        rd(3'd3, 32'h0, "t5_reset_counter");

        wr(3'd1, 32'hABCD1234);
        rd(3'd1, 32'h00001234, "t6_prescale_read");
        n_chk++;
        if (bus.rdata === 32'h00001234) n_pass++;
        else $display("FAIL direct_prescale_read: got 0x%08h", bus.rdata);
        rd(3'd6, 32'h0, "t6_addr6_zero");
        wr(3'd5, 32'hFFFFFFFF);
        rd(3'd5, 32'h0, "t6_addr5_zero");
        rd(3'd0, 32'h0, "t6_ctrl_untouched");
        rd(3'd1, 32'h00001234, "t6_prescale_untouched");
        rd(3'd2, 32'h0, "t6_compare_untouched");
        wr(3'd0, 32'hFFFFFFF6);
        rd(3'd0, 32'h16, "t6_ctrl_masked");
        idle(3);

        foreach (sb[i]) begin
            n_chk++;
            $display("FAIL %s: never checked, expected 0x%08h at cycle %0d", sb[i].name, sb[i].exp, sb[i].at);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/compare_timer.md
Name: compare_timer

Overview:
- Memory-mapped 16-bit timer/counter peripheral inside the microcontroller. Two instances drive the TIM1_CMP and TIM2_CMP pins.
- Contents: a programmable prescaler, an up-counter, a compare register, a compare output with off/toggle/pulse/PWM modes, and a level interrupt request to the interrupt controller.
- Sits on the core's peripheral data bus, downstream of the load/store unit.

Parameters:
- WIDTH, 16, counter and compare register width (1..32).
- PRESCALE_WIDTH, 16, prescaler divider width (1..32).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sel  in  1  peripheral selected this cycle.
- we  in  1  write strobe; qualified by sel.
- addr  in  3  word register index.
- wdata  in  32  write data.
- rdata  out  32  read data; registered, valid the cycle after sel && !we.
- cmp_out  out  1  compare output pin; registered.
- irq  out  1  level interrupt request.

Behaviour:
- Register map (addr):
  - 0 CTRL: bit0 EN; bits2:1 MODE (00 off, 01 toggle, 10 pulse, 11 PWM); bit3 AUTORELOAD; bit4 IRQEN.
  - 1 PRESCALE.
  - 2 COMPARE.
  - 3 COUNTER.
  - 4 STATUS: bit0 MATCH, sticky.
  - Addresses 5..7: read 0, writes ignored. Unused upper bits read 0.
- Reset: all registers 0; pcnt 0; rdata 0; cmp_out 0; irq 0. Reset mid-count aborts everything in that cycle.
- Prescaler:
  - While EN=1: tick asserted for one clk when pcnt==PRESCALE, with pcnt←0; otherwise pcnt←pcnt+1.
  - While EN=0: pcnt and counter hold, and no tick.
  - Tick period is PRESCALE+1 clocks; PRESCALE=0 gives a tick every clock.
- Counter, on tick:
  - match_evt = (counter==COMPARE).
  - If match_evt && AUTORELOAD: counter←0. Otherwise counter←counter+1, wrapping 2^WIDTH−1→0.
  - Autoreload period is (COMPARE+1)*(PRESCALE+1) clocks.
- MATCH flag: set on match_evt. Cleared by a STATUS write with wdata[0]=1. If set and clear land in the same cycle, set wins.
- irq = MATCH & IRQEN, registered; it follows MATCH by one clock.
- cmp_out by MODE (all registered, updated one clock after the tick):
  - 00: 0.
  - 01: inverts on each match_evt.
  - 10: high for exactly one clock per match_evt.
  - 11: (counter_next < COMPARE).
  - A MODE write takes effect the next clock. Switching to 01 keeps the current level.
- Bus writes:
  - A COUNTER write loads counter and clears pcnt. It overrides any same-cycle tick; no match_evt is generated in that cycle.
  - A PRESCALE write clears pcnt.
  - A COMPARE write is used from the next tick onward. If COMPARE is set below the current counter without autoreload, the counter runs to wrap and matches on the next pass.
- Disabling (EN 1→0):
  - Toggle-mode level holds.
  - A pending pulse still completes its single cycle.
  - PWM output holds its last value.
- Reads: rdata←register selected by addr one clock after sel && !we, otherwise holds. COUNTER reads return the value before any same-cycle update.

Decomposition:
- Package timer_pkg holds:
  - register index constants (REG_CTRL..REG_STATUS);
  - MODE encodings (MODE_OFF, MODE_TOGGLE, MODE_PULSE, MODE_PWM);
  - CTRL bit positions.
- Sub-module timer_prescaler (clk, reset, en, clear, divisor → tick) is natural.
- The counter, compare, output and bus logic stay in compare_timer.

Test Plan:
- Tick period: PRESCALE=3, COMPARE=4, AUTORELOAD=1, MODE=01, EN=1 → counter steps every 4 clocks; cmp_out toggles every 20 clocks; MATCH set after the first 20 clocks.
- Pulse and interrupt: MODE=10, PRESCALE=0, COMPARE=2, AUTORELOAD=1, IRQEN=1 → cmp_out one-clock pulse every 3 clocks; irq rises 1 clock after MATCH. STATUS write of 1 clears irq unless a match lands in the same cycle, in which case MATCH stays 1.
- PWM: MODE=11, PRESCALE=0, COMPARE=3, AUTORELOAD with period 8 emulated by COMPARE=7 and duty threshold tested separately → cmp_out high while counter_next<COMPARE; verify duty 3/4 at COMPARE=3 with autoreload.
- Wrap without autoreload: WIDTH=16, write COUNTER=0xFFFE, COMPARE=0x0001, PRESCALE=0 → counter FFFF, 0000, 0001; match_evt on the tick where counter==0x0001; no match at wrap.
- Write collision: COUNTER write of 0x0010 in a tick cycle where counter==COMPARE → counter=0x0010, no MATCH, pcnt=0. Separately, assert reset mid-count → all outputs 0 next clock.
- Bus reads: write PRESCALE=0x1234, read addr 1 → rdata=0x00001234 one clock after. Read addr 6 → 0. A write to addr 5 changes nothing.
